// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state type, line sizing and address helper for dcache_mem_responder
`ifndef DCACHE_B
`define DCACHE_B 4
`endif

package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCEPT,
      RD_ISSUE,
      RD_DRAIN,
      WR_BURST
   } resp_state_t;

   localparam int LINE_WORDS = 2 ** (`DCACHE_B - 2);
   localparam int BEAT_W     = $clog2(LINE_WORDS) + 1;

   // Word address of the first word of the line containing byte address a.
   function automatic logic [31:0] line_word_base(input logic [31:0] a, input int offset_w);
      line_word_base = (a >> offset_w) << (offset_w - 2);
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - MEM_LATENCY-deep valid shift register turning read issues into return strobes
module mem_rd_pipe #(
   parameter int LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic issue,
   output logic ret
);

   logic [LATENCY-1:0] sr;

   generate
      if (LATENCY == 1) begin : g_one
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sr <= '0;
            else       sr <= issue;
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sr <= '0;
            else       sr <= {sr[LATENCY-2:0], issue};
         end
      end
   endgenerate

   assign ret = sr[LATENCY-1];

endmodule

// File: rtl/dcache_mem_responder.sv
// rtl/dcache_mem_responder.sv - line-fill / write-back burst responder in front of a synchronous SRAM
// Optional DCACHE_RESP_WLAST_CHECK_EN adds the sticky wlast_err output.
module dcache_mem_responder #(
   parameter int OFFSET_WIDTH = `DCACHE_B,
   parameter int LINE_WORDS   = 2 ** (`DCACHE_B - 2),
   parameter int MEM_LATENCY  = 1,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_req,
   input  logic                  mem_wr,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic                  mem_wlast,
   output logic                  mem_addr_ok,
   output logic                  mem_data_ok,
   output logic [31:0]           mem_rdata,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-3:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
`ifdef DCACHE_RESP_WLAST_CHECK_EN
   ,
   output logic                  wlast_err
`endif
);

   import dcache_pkg::*;

   localparam int               CNT_W     = $clog2(LINE_WORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

   resp_state_t           state, state_nxt;
   logic [CNT_W-1:0]      beat, ret_cnt;
   logic [ADDR_WIDTH-3:0] base;
   logic                  wr_q;
   logic                  wr_beat;
   logic                  rd_ret;
   logic [31:0]           rdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         beat    <= '0;
         ret_cnt <= '0;
         base    <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && mem_req) begin
            base <= (ADDR_WIDTH-2)'(line_word_base(32'(mem_addr), OFFSET_WIDTH));
            wr_q <= mem_wr;
         end
         if (state == ACCEPT)
            beat <= '0;
         else if (state == RD_ISSUE || state == WR_BURST)
            beat <= beat + 1'b1;
         if (state == ACCEPT)
            ret_cnt <= '0;
         else if (rd_ret)
            ret_cnt <= ret_cnt + 1'b1;
         if (rd_ret)
            rdata_q <= sram_rdata;
      end
   end

   always_comb begin
      state_nxt   = state;
      mem_addr_ok = 1'b0;
      sram_en     = 1'b0;
      sram_we     = 1'b0;
      wr_beat     = 1'b0;
      case (state)
         IDLE:     if (mem_req) state_nxt = ACCEPT;
         ACCEPT: begin
            mem_addr_ok = 1'b1;
            state_nxt   = wr_q ? WR_BURST : RD_ISSUE;
         end
         RD_ISSUE: begin
            sram_en = 1'b1;
            if (beat == LAST_BEAT) state_nxt = RD_DRAIN;
         end
         // Last return is the one that arrives while LINE_WORDS-1 have already been counted.
         RD_DRAIN: if (rd_ret && ret_cnt == LAST_BEAT) state_nxt = IDLE;
         WR_BURST: begin
            sram_en = 1'b1;
            sram_we = 1'b1;
            wr_beat = 1'b1;
            if (beat == LAST_BEAT) state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   mem_rd_pipe #(.LATENCY(MEM_LATENCY)) u_rd_pipe (
      .clk   (clk),
      .reset (reset),
      .issue (sram_en & ~sram_we),
      .ret   (rd_ret)
   );

   assign mem_data_ok = rd_ret | wr_beat;
   assign mem_rdata   = rd_ret ? sram_rdata : rdata_q;
   assign sram_addr   = sram_en ? base + (ADDR_WIDTH-2)'(beat) : '0;
   assign sram_wdata  = wr_beat ? mem_wdata : '0;

`ifdef DCACHE_RESP_WLAST_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wlast_err <= 1'b0;
      else if (wr_beat && (mem_wlast != (beat == LAST_BEAT)))
         wlast_err <= 1'b1;
   end
`else
   logic unused_wlast;
   assign unused_wlast = mem_wlast;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb/tb_dcache_mem_responder.sv - randomized scoreboard bench for dcache_mem_responder
`timescale 1ns/1ps
module tb_dcache_mem_responder;
   import dcache_pkg::*;

   localparam int LAT = 3;
   localparam int LW  = LINE_WORDS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req = 1'b0, mem_wr = 1'b0, mem_wlast = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic        mem_addr_ok, mem_data_ok, sram_en, sram_we;
   logic [31:0] mem_rdata, sram_wdata, sram_rdata;
   logic [29:0] sram_addr;
`ifdef DCACHE_RESP_WLAST_CHECK_EN
   logic        wlast_err;
`endif

   dcache_mem_responder #(
      .OFFSET_WIDTH (`DCACHE_B),
      .LINE_WORDS   (LW),
      .MEM_LATENCY  (LAT),
      .ADDR_WIDTH   (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wlast   (mem_wlast),
      .mem_addr_ok (mem_addr_ok),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata),
      .sram_en     (sram_en),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata)
`ifdef DCACHE_RESP_WLAST_CHECK_EN
      ,
      .wlast_err   (wlast_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      bit          wr;
      logic [31:0] data;
      logic [29:0] addr;
   } beat_t;

   beat_t       beat_q[$];
   int unsigned ok_q[$];
   int unsigned cyc;
   int unsigned idle_at;
   int          checks, failures;
   logic [31:0] last_rd = '0;
   logic [31:0] ref_m[1024];
   bit   [31:0] sram_m[1024];
   logic [31:0] rd_pipe[LAT];

   function automatic logic [31:0] pat(input int i);
      return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: contents stored XORed with a per-word pattern so unwritten words read back pat(i).
   always @(posedge clk) begin
      if (sram_en && sram_we) sram_m[sram_addr[9:0]] <= sram_wdata ^ pat(int'(sram_addr[9:0]));
      rd_pipe[0] <= (sram_en && !sram_we) ? (sram_m[sram_addr[9:0]] ^ pat(int'(sram_addr[9:0]))) : 32'h0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rdata = rd_pipe[LAT-1];

   always @(negedge clk) begin
      beat_t e;
      if (!reset) begin
         if (mem_addr_ok && mem_data_ok) check("addr_ok_and_data_ok", 1, 0);
         if (mem_addr_ok) begin
            if (ok_q.size() == 0) check("addr_ok_unexpected", 1, 0);
            else                  check("addr_ok_cycle", 64'(cyc), 64'(ok_q.pop_front()));
         end
         if (mem_data_ok) begin
            if (beat_q.size() == 0) check("data_ok_unexpected", 1, 0);
            else begin
               e = beat_q.pop_front();
               check("data_ok_cycle", 64'(cyc), 64'(e.cyc));
               if (e.wr) begin
                  check("wr_sram_en_we", {sram_en, sram_we}, 2'b11);
                  check("wr_sram_addr", 64'(sram_addr), 64'(e.addr));
                  check("wr_sram_wdata", sram_wdata, e.data);
               end else begin
                  check("rd_data", mem_rdata, e.data);
                  last_rd = e.data;
               end
            end
         end else if (mem_rdata !== last_rd) begin
            check("rdata_hold", mem_rdata, last_rd);
         end
      end
   end

   task automatic burst(input bit wr, input logic [31:0] addr, input bit bad_wlast, input bit rst_mid);
      logic [31:0] w[LW];
      int          b, n;
      int unsigned t;
      b = int'(addr[11:2]) & ~(LW - 1);
      while (cyc < idle_at) begin @(posedge clk); #1; end
      mem_req  = 1'b1;
      mem_wr   = wr;
      mem_addr = addr;
      t = cyc + 1;
      ok_q.push_back(t);
      for (int k = 0; k < LW; k++) begin
         if (wr) begin
            w[k] = $urandom;
            ref_m[b+k] = w[k];
            beat_q.push_back('{t + 1 + k, 1'b1, w[k], 30'(b + k)});
         end else begin
            beat_q.push_back('{t + 1 + k + LAT, 1'b0, ref_m[b+k], 30'(b + k)});
         end
      end
      idle_at = wr ? t + LW + 1 : t + LW + LAT + 1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!mem_addr_ok && n < 20);
      check("addr_ok_seen", mem_addr_ok, 1);
      mem_req  = 1'b0;
      mem_wr   = 1'($urandom);
      mem_addr = $urandom;
      if (wr) begin
         for (int k = 0; k < LW; k++) begin
            @(posedge clk); #1;
            mem_wdata = w[k];
            mem_wlast = bad_wlast ? (k == 1) : (k == LW - 1);
         end
      end
      if (rst_mid) begin
         while (cyc < t + 3) begin @(posedge clk); #1; end
         reset = 1'b1;
         #1;
         check("reset_mid_outputs_zero",
               {mem_addr_ok, mem_data_ok, mem_rdata, sram_en, sram_we, sram_addr, sram_wdata}, '0);
         ok_q.delete();
         beat_q.delete();
         repeat (2) @(posedge clk);
         #1;
         reset   = 1'b0;
         last_rd = '0;
         idle_at = cyc;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_m[i] = pat(i);
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_zero",
            {mem_addr_ok, mem_data_ok, mem_rdata, sram_en, sram_we, sram_addr, sram_wdata}, '0);
`ifdef DCACHE_RESP_WLAST_CHECK_EN
      check("wlast_err_reset", wlast_err, 0);
`endif
      reset   = 1'b0;
      idle_at = cyc;

      burst(1'b0, 32'h100, 1'b0, 1'b0);
      burst(1'b1, 32'h20C, 1'b0, 1'b0);
      burst(1'b1, 32'h340, 1'b0, 1'b0);
      burst(1'b0, 32'h344, 1'b0, 1'b0);
      burst(1'b0, 32'h180, 1'b0, 1'b1);
      burst(1'b0, 32'h20C, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         idle_at += $urandom_range(0, 3);
         burst(1'($urandom_range(0, 1)), 32'($urandom_range(0, 4095)), 1'b0, 1'b0);
      end

`ifdef DCACHE_RESP_WLAST_CHECK_EN
      while (cyc < idle_at) begin @(posedge clk); #1; end
      check("wlast_err_clean", wlast_err, 0);
      burst(1'b1, 32'h400, 1'b1, 1'b0);
      while (cyc < idle_at + 3) begin @(posedge clk); #1; end
      check("wlast_err_sticky", wlast_err, 1);
`endif

      while (cyc < idle_at + 2) begin @(posedge clk); #1; end
      check("beats_outstanding", 64'(beat_q.size()), 0);
      check("addr_ok_outstanding", 64'(ok_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
